// File: rtl/core_wb_bridge.sv
// Bridges a core request/hold memory port onto a Wishbone classic master.
// Adds cycle framing, a core stall, an optional response register stage and an optional bus timeout.
module core_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RESP_REG       = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] core_sel_i,
  output logic                    core_hold_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_rvalid_o,
  output logic                    core_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic [CNT_WIDTH-1:0]    txn_count_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, DONE} state_t;

  // Wait-counter value of the last allowed strobe cycle; unused when the timeout is disabled.
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_t                  state_reg, state_next;
  logic [CNT_WIDTH-1:0]    wait_cnt_reg;
  logic [CNT_WIDTH-1:0]    txn_reg;
  logic [DATA_WIDTH-1:0]   resp_data_reg;
  logic                    resp_err_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    err_reg;

  logic                    timeout_hit;
  logic                    bus_done;
  logic                    comp_err;
  logic [DATA_WIDTH-1:0]   comp_data;

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt_reg == TIMEOUT_LAST);

  always_comb begin
    state_next = state_reg;
    bus_done   = 1'b0;
    // Timeout without ack reports an error, and err outranks a simultaneous ack.
    comp_err   = wb_err_i | ~wb_ack_i;
    comp_data  = '0;
    if (wb_ack_i && !wb_err_i && !wb_we_o)
      comp_data = wb_data_i;
    case (state_reg)
      IDLE: if (core_req_i) state_next = BUS;
      BUS: begin
        if (wb_ack_i || wb_err_i || timeout_hit) begin
          bus_done   = 1'b1;
          state_next = (RESP_REG != 0) ? RESP : DONE;
        end
      end
      RESP:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wb_we_o       <= 1'b0;
      wb_addr_o     <= '0;
      wb_data_o     <= '0;
      wb_sel_o      <= '0;
      wait_cnt_reg  <= '0;
      txn_reg       <= '0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && core_req_i) begin
        wb_we_o      <= core_we_i;
        wb_addr_o    <= core_addr_i;
        wb_data_o    <= core_wdata_i;
        wb_sel_o     <= core_sel_i;
        wait_cnt_reg <= '0;
      end
      if (state_reg == BUS && !bus_done && wait_cnt_reg != '1)
        wait_cnt_reg <= wait_cnt_reg + CNT_WIDTH'(1);
      if (bus_done) begin
        resp_data_reg <= comp_data;
        resp_err_reg  <= comp_err;
        if (RESP_REG == 0) begin
          rdata_reg <= comp_data;
          err_reg   <= comp_err;
        end
      end
      if (state_reg == RESP) begin
        rdata_reg <= resp_data_reg;
        err_reg   <= resp_err_reg;
      end
      // Counted on entry to DONE so the count already includes the transaction being reported.
      if (state_next == DONE)
        txn_reg <= txn_reg + CNT_WIDTH'(1);
    end
  end

  assign wb_cyc_o      = (state_reg == BUS);
  assign wb_stb_o      = (state_reg == BUS);
  assign core_rvalid_o = (state_reg == DONE);
  assign core_err_o    = core_rvalid_o & err_reg;
  assign core_rdata_o  = rdata_reg;
  assign core_hold_o   = core_req_i & ~core_rvalid_o;
  assign txn_count_o   = txn_reg;

endmodule
